chip8_mem_arbiter: RTL and testbench

Parametrised N-client arbiter in front of the single shared read/write port of the CHIP-8 unified memory BRAM (RAM, VRAM, registers, stack). Each client (processor, video, debug, flash loader, …) issues requests through its own valid/ready channel with a one-entry holding buffer. Fixed-priority or round-robin arbitration selects one request per cycle. Read data is routed back to the requesting client through a tag pipeline matched to the memory read latency. Address translation into memory regions is the client's job; this block passes full BRAM addresses.

---
 rtl/chip8_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: N-client arbiter for the shared CHIP-8 memory port.
// Buffered valid/ready requests, fixed or round-robin grant, tagged reads.
module chip8_mem_arbiter #(
    parameter int NUM_CLIENTS  = 3,
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 2,
    parameter int ROUND_ROBIN  = 0,
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [NUM_CLIENTS-1:0]            req_valid_in,
    output logic [NUM_CLIENTS-1:0]            req_ready_out,
    input  logic [NUM_CLIENTS-1:0]            req_we_in,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_CLIENTS*WIDTH-1:0]      req_data_in,
    output logic [NUM_CLIENTS-1:0]            resp_valid_out,
    output logic [WIDTH-1:0]                  resp_data_out,
    output logic                              mem_en_out,
    output logic                              mem_we_out,
    output logic [ADDR_WIDTH-1:0]             mem_addr_out,
    output logic [WIDTH-1:0]                  mem_wdata_out,
    input  logic [WIDTH-1:0]                  mem_rdata_in,
    output logic [IW-1:0]                     grant_idx_out
);

    localparam int N  = NUM_CLIENTS;
    localparam int RL = READ_LATENCY;

    logic [N-1:0]                 pend_q;
    logic [N-1:0]                 pend_d;
    logic [N-1:0]                 hs;
    logic [N-1:0]                 bwe_q;
    logic [N-1:0][ADDR_WIDTH-1:0] baddr_q;
    logic [N-1:0][WIDTH-1:0]      bdata_q;

    logic                         gnt_any;
    logic [IW-1:0]                gnt_idx;
    logic [IW-1:0]                last_q;
    int                           start;
    int                           cand;
    logic [IW-1:0]                cidx;

    logic                         mem_en_q;
    logic                         mem_we_q;
    logic [ADDR_WIDTH-1:0]        mem_addr_q;
    logic [WIDTH-1:0]             mem_wdata_q;
    logic [IW-1:0]                gidx_q;

    logic [RL-1:0]                tag_v_q;
    logic [RL-1:0][IW-1:0]        tag_idx_q;
    logic [N-1:0]                 resp_v_q;
    logic [N-1:0]                 resp_v_d;
    logic [WIDTH-1:0]             resp_data_q;

    // A buffer accepts only when empty, so ready never depends on valid
    assign hs = req_valid_in & ~pend_q;

    // Pick the first pending buffer, starting after the last winner in RR mode
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        cidx    = '0;
        start   = (ROUND_ROBIN != 0) ? (int'(last_q) + 1) % N : 0;
        for (int i = 0; i < N; i++) begin
            cand = (start + i) % N;
            cidx = IW'(cand);
            if (!gnt_any && pend_q[cidx]) begin
                gnt_any = 1'b1;
                gnt_idx = cidx;
            end
        end
    end

    // Set pending on handshake, clear it on grant (never the same client)
    always_comb begin
        pend_d = pend_q | hs;
        if (gnt_any) begin
            pend_d[gnt_idx] = 1'b0;
        end
    end

    // Holding buffers latch request fields on handshake
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_q  <= '0;
            bwe_q   <= '0;
            baddr_q <= '0;
            bdata_q <= '0;
        end else begin
            pend_q <= pend_d;
            for (int k = 0; k < N; k++) begin
                if (hs[k]) begin
                    bwe_q[k]   <= req_we_in[k];
                    baddr_q[k] <= req_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
                    bdata_q[k] <= req_data_in[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Register the winner onto the memory port; address/data hold when idle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            gidx_q      <= '0;
        end else if (gnt_any) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= bwe_q[gnt_idx];
            mem_addr_q  <= baddr_q[gnt_idx];
            mem_wdata_q <= bdata_q[gnt_idx];
            gidx_q      <= gnt_idx;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end
    end

    // Round-robin pointer moves only when something is granted
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_q <= IW'(N - 1);
        end else if (gnt_any) begin
            last_q <= gnt_idx;
        end
    end

    // Tag pipeline tracks read owners across the memory latency
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tag_v_q   <= '0;
            tag_idx_q <= '0;
        end else begin
            tag_v_q[0]   <= mem_en_q & ~mem_we_q;
            tag_idx_q[0] <= gidx_q;
            for (int s = 1; s < RL; s++) begin
                tag_v_q[s]   <= tag_v_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    // One-hot response strobe for the owner of the returning read
    always_comb begin
        resp_v_d = '0;
        if (tag_v_q[RL-1]) begin
            resp_v_d[tag_idx_q[RL-1]] = 1'b1;
        end
    end

    // Capture read data; keep the last value between responses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            resp_v_q    <= '0;
            resp_data_q <= '0;
        end else begin
            resp_v_q <= resp_v_d;
            if (tag_v_q[RL-1]) begin
                resp_data_q <= mem_rdata_in;
            end
        end
    end

    assign req_ready_out  = ~pend_q;
    assign resp_valid_out = resp_v_q;
    assign resp_data_out  = resp_data_q;
    assign mem_en_out     = mem_en_q;
    assign mem_we_out     = mem_we_q;
    assign mem_addr_out   = mem_addr_q;
    assign mem_wdata_out  = mem_wdata_q;
    assign grant_idx_out  = gidx_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: scoreboard bench for the memory arbiter.
// Fixed-priority 3-client instance plus a 4-client round-robin instance.
module tb_chip8_mem_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int AW = 13;
    localparam int RN = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    resp_valid;
    logic [W-1:0]    resp_data;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rdata;
    logic [1:0]      gidx;

    logic [RN-1:0]    rr_valid;
    logic [RN-1:0]    rr_ready;
    logic [RN-1:0]    rr_we;
    logic [RN*AW-1:0] rr_addr;
    logic [RN*W-1:0]  rr_data;
    logic [RN-1:0]    rr_resp_valid;
    logic [W-1:0]     rr_resp_data;
    logic             rr_mem_en;
    logic             rr_mem_we;
    logic [AW-1:0]    rr_mem_addr;
    logic [W-1:0]     rr_mem_wdata;
    logic [W-1:0]     rr_rdata;
    logic [1:0]       rr_gidx;

    chip8_mem_arbiter dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_we_in(req_we), .req_addr_in(req_addr),
        .req_data_in(req_data), .resp_valid_out(resp_valid),
        .resp_data_out(resp_data), .mem_en_out(mem_en),
        .mem_we_out(mem_we), .mem_addr_out(mem_addr),
        .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata),
        .grant_idx_out(gidx)
    );

    chip8_mem_arbiter #(.NUM_CLIENTS(RN), .ROUND_ROBIN(1)) dut_rr (
        .clk_in(clk), .rst_n_in(rst_n),
        .req_valid_in(rr_valid), .req_ready_out(rr_ready),
        .req_we_in(rr_we), .req_addr_in(rr_addr),
        .req_data_in(rr_data), .resp_valid_out(rr_resp_valid),
        .resp_data_out(rr_resp_data), .mem_en_out(rr_mem_en),
        .mem_we_out(rr_mem_we), .mem_addr_out(rr_mem_addr),
        .mem_wdata_out(rr_mem_wdata), .mem_rdata_in(rr_rdata),
        .grant_idx_out(rr_gidx)
    );

    int total = 0;
    int bad   = 0;

    stim_t      sq  [N][$];
    logic [7:0] exq [N][$];
    int         glog[$];
    int         rlog[$];
    int         rr_glog[$];
    int         rcnt[N];

    bit [7:0] wmem [8192];
    bit       wflag[8192];
    bit [7:0] smem [8192];
    bit       sflag[8192];
    logic [7:0] rd1;

    int exp_g[9] = '{-1, -1, 0, 1, 0, 2, 0, -1, 0};
    int exp_r[6] = '{0, 1, 0, 2, 0, 0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        if (a == 13'h1005) return 8'hA5;
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int outstanding();
        int n = 0;
        for (int k = 0; k < N; k++) n += sq[k].size() + exq[k].size();
        return n;
    endfunction

    task automatic post(input int k, input logic we,
                        input logic [AW-1:0] a, input logic [W-1:0] d);
        stim_t s;
        s.we = we;
        s.addr = a;
        s.data = d;
        sq[k].push_back(s);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (n < maxc && outstanding() != 0) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(outstanding()), 32'd0);
    endtask

    task automatic check_reset();
        check("rst_ready", 32'(req_ready), 32'h7);
        check("rst_resp_v", 32'(resp_valid), 32'h0);
        check("rst_resp_d", 32'(resp_data), 32'h0);
        check("rst_en", 32'(mem_en), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_gidx", 32'(gidx), 32'h0);
        check("rst_rr_ready", 32'(rr_ready), 32'hF);
        check("rst_rr_en", 32'(rr_mem_en), 32'h0);
    endtask

    // BRAM model: 2-cycle read latency, write-through storage
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr]  <= mem_wdata;
            wflag[mem_addr] <= 1'b1;
        end
        rd1 <= wflag[mem_addr] ? wmem[mem_addr] : init_val(mem_addr);
        mem_rdata <= rd1;
    end

    // Driver: present queued requests when ready, junk while blocked
    initial begin : driver
        stim_t s;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!rst_n) begin
                    req_valid[k] = 1'b0;
                end else if (!req_ready[k]) begin
                    req_valid[k] = 1'b1;
                    req_we[k] = 1'($urandom);
                    req_addr[k*AW +: AW] = AW'($urandom);
                    req_data[k*W +: W] = W'($urandom);
                end else if (sq[k].size() > 0) begin
                    s = sq[k].pop_front();
                    req_valid[k] = 1'b1;
                    req_we[k] = s.we;
                    req_addr[k*AW +: AW] = s.addr;
                    req_data[k*W +: W] = s.data;
                    if (s.we) begin
                        smem[s.addr]  = s.data;
                        sflag[s.addr] = 1'b1;
                    end else begin
                        exq[k].push_back(sflag[s.addr] ? smem[s.addr]
                                                       : init_val(s.addr));
                    end
                end else begin
                    req_valid[k] = 1'b0;
                end
            end
        end
    end

    // Monitor: log grants and responses, score read data
    initial begin : monitor
        forever begin
            @(negedge clk);
            glog.push_back(mem_en ? int'(gidx) : -1);
            rr_glog.push_back(rr_mem_en ? int'(rr_gidx) : -1);
            if (resp_valid != '0)
                check("resp_onehot", 32'($onehot(resp_valid)), 32'd1);
            for (int k = 0; k < N; k++) begin
                if (resp_valid[k]) begin
                    rcnt[k]++;
                    rlog.push_back(k);
                    if (exq[k].size() == 0)
                        check("spurious_resp", 32'(resp_valid), 32'd0);
                    else
                        check("rdata", 32'(resp_data),
                              32'(exq[k].pop_front()));
                end
            end
        end
    end

    initial begin : main
        int c0, c1, c2, first;
        rst_n    = 1'b1;
        rr_valid = '0;
        rr_we    = '0;
        rr_data  = '0;
        rr_rdata = 8'h00;
        rr_addr  = {13'h3, 13'h2, 13'h1, 13'h0};
        for (int k = 0; k < N; k++) rcnt[k] = 0;

        #2 rst_n = 1'b0;
        #1 check_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_ready", 32'(req_ready), 32'h7);

        // single read, client 1
        @(posedge clk); #1;
        post(1, 1'b0, 13'h1005, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("sr_ready_e0", 32'(req_ready), 32'h5);
        check("sr_en_e0", 32'(mem_en), 32'h0);
        @(negedge clk);
        check("sr_en_e1", 32'(mem_en), 32'h1);
        check("sr_we_e1", 32'(mem_we), 32'h0);
        check("sr_addr_e1", 32'(mem_addr), 32'h1005);
        check("sr_gidx_e1", 32'(gidx), 32'h1);
        check("sr_ready_e1", 32'(req_ready), 32'h7);
        @(negedge clk);
        check("sr_resp_e2", 32'(resp_valid), 32'h0);
        @(negedge clk);
        check("sr_resp_e3", 32'(resp_valid), 32'h0);
        @(negedge clk);
        check("sr_resp_e4", 32'(resp_valid), 32'h2);
        check("sr_data_e4", 32'(resp_data), 32'hA5);
        @(negedge clk);
        check("sr_resp_e5", 32'(resp_valid), 32'h0);
        check("sr_hold_e5", 32'(resp_data), 32'hA5);

        // write then read, client 2
        c0 = rcnt[0]; c1 = rcnt[1]; c2 = rcnt[2];
        @(posedge clk); #1;
        post(2, 1'b1, 13'h0200, 8'h3C);
        post(2, 1'b0, 13'h0200, 8'h00);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("wr_en", 32'(mem_en), 32'h1);
        check("wr_we", 32'(mem_we), 32'h1);
        check("wr_addr", 32'(mem_addr), 32'h0200);
        check("wr_wdata", 32'(mem_wdata), 32'h3C);
        check("wr_gidx", 32'(gidx), 32'h2);
        @(negedge clk);
        @(negedge clk);
        check("rd_en", 32'(mem_en), 32'h1);
        check("rd_we", 32'(mem_we), 32'h0);
        check("rd_addr", 32'(mem_addr), 32'h0200);
        drain(40);
        repeat (6) @(negedge clk);
        check("wr_rd_cnt2", 32'(rcnt[2] - c2), 32'd1);
        check("wr_rd_cnt01", 32'((rcnt[0] - c0) + (rcnt[1] - c1)), 32'd0);

        // fixed-priority contention
        @(posedge clk); #1;
        glog.delete();
        rlog.delete();
        for (int i = 0; i < 4; i++) post(0, 1'b0, AW'(13'h010 + i), 8'h00);
        post(1, 1'b0, 13'h020, 8'h00);
        post(2, 1'b0, 13'h030, 8'h00);
        drain(60);
        repeat (6) @(negedge clk);
        check("cont_glen", 32'(glog.size() >= 9), 32'd1);
        for (int i = 0; i < 9; i++)
            check("cont_grant", 32'(glog[i]), 32'(exp_g[i]));
        check("cont_rlen", 32'(rlog.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check("cont_resp_order", 32'(rlog[i]), 32'(exp_r[i]));

        // round-robin, all four clients always requesting
        @(posedge clk); #1;
        rr_glog.delete();
        rr_valid = '1;
        repeat (24) @(negedge clk);
        rr_valid = '0;
        first = -1;
        for (int i = 0; i < rr_glog.size(); i++)
            if (first < 0 && rr_glog[i] >= 0) first = i;
        check("rr_first", 32'(first), 32'd2);
        if (first < 0) first = 0;
        for (int i = 0; i < 16; i++)
            check("rr_seq", 32'(rr_glog[first+i]), 32'(i % 4));

        // reset with two reads in flight
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        post(0, 1'b0, 13'h040, 8'h00);
        post(1, 1'b0, 13'h041, 8'h00);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        for (int k = 0; k < N; k++) exq[k].delete();
        #1 check_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = rcnt[0]; c1 = rcnt[1]; c2 = rcnt[2];
        repeat (8) @(negedge clk);
        check("rif_no_resp",
              32'((rcnt[0] - c0) + (rcnt[1] - c1) + (rcnt[2] - c2)), 32'd0);
        check("rif_ready", 32'(req_ready), 32'h7);
        @(posedge clk); #1;
        post(0, 1'b0, 13'h041, 8'h00);
        drain(40);
        repeat (4) @(negedge clk);
        check("rif_next_cnt", 32'(rcnt[0] - c0), 32'd1);
        check("end_empty", 32'(outstanding()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
